// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the riscv32 pipeline. Holds the fetch PC, drives
// it to the branch predictor, issues one instruction-memory request at a time
// over a valid/ready handshake, and presents the fetched instruction together
// with the prediction that was used for it to the decode stage. EX-stage
// redirects replace the fetch PC; any memory response that a redirect made
// stale is absorbed and discarded.
//
// Parameters
//   RESET_PC        first fetch address after reset
//
// Ports
//   clk             pipeline clock
//   rst             synchronous, active-low reset
//   PC_now          current fetch PC, to the predictor
//   taken_predict   predictor direction for PC_now
//   PC_predict      predictor target for PC_now
//   PC              instruction-memory request address
//   Inst_Req_Valid  request valid
//   Inst_Req_Ready  memory accepts the request
//   Instruction     response data
//   Inst_Valid      response valid
//   Inst_Ready      fetch accepts the response
//   redirect_valid  EX correction pulse (ignored while idle after reset)
//   redirect_pc     corrected fetch target
//   if_valid        IF/ID entry valid
//   if_ready        decode accepts the entry
//   if_pc           PC of the entry
//   if_inst         instruction of the entry
//   if_pred_taken   predicted direction used for the entry
//   if_pred_pc      predicted next PC for the entry
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,

  output logic [31:0] PC_now,
  input  logic        taken_predict,
  input  logic [31:0] PC_predict,

  output logic [31:0] PC,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  input  logic [31:0] Instruction,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,

  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,

  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic        pred_taken_q, pred_taken_d;

  // Sequential PC increment; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Control state and the fetch PC are reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  // Datapath holding registers are only meaningful once written in the
  // handshake that fills them, so they carry no reset.
  always_ff @(posedge clk) begin
    npc_q  <= npc_d;
    inst_q <= inst_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    npc_d        = npc_q;
    kill_d       = kill_q;
    inst_d       = inst_q;
    pred_taken_d = pred_taken_q;

    case (state_q)
      S_IDLE: begin
        // Redirects are not honoured here; the first request goes out next.
        state_d = S_REQ;
      end

      S_REQ: begin
        if (Inst_Req_Ready) begin
          // Predictor output belongs to the PC being handed to memory now.
          pred_taken_d = taken_predict;
          npc_d        = taken_predict ? PC_predict : pc_plus4(pc_q);
          state_d      = S_WAIT;
          if (redirect_valid) begin
            // The request already left with the old address; its response
            // must be swallowed when it returns.
            kill_d = 1'b1;
            pc_d   = redirect_pc;
          end
        end else if (redirect_valid) begin
          // Nothing has been sampled by memory yet, so just retarget.
          pc_d = redirect_pc;
        end
      end

      S_WAIT: begin
        if (Inst_Valid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) begin
              pc_d = redirect_pc;
            end
          end else begin
            inst_d  = Instruction;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
          pc_d   = redirect_pc;
        end
      end

      S_HOLD: begin
        // A redirect drops the entry even if decode accepts it this cycle.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_d    = npc_q;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign PC_now         = pc_q;
  assign PC             = pc_q;
  assign Inst_Req_Valid = (state_q == S_REQ);
  assign Inst_Ready     = (state_q == S_WAIT);

  assign if_valid       = (state_q == S_HOLD);
  assign if_pc          = pc_q;
  assign if_inst        = inst_q;
  assign if_pred_taken  = pred_taken_q;
  assign if_pred_pc     = npc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_now;
  logic        taken_predict;
  logic [31:0] PC_predict;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_pred_taken;
  logic [31:0] if_pred_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .PC_now         (PC_now),
    .taken_predict  (taken_predict),
    .PC_predict     (PC_predict),
    .PC             (PC),
    .Inst_Req_Valid (Inst_Req_Valid),
    .Inst_Req_Ready (Inst_Req_Ready),
    .Instruction    (Instruction),
    .Inst_Valid     (Inst_Valid),
    .Inst_Ready     (Inst_Ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_pred_taken  (if_pred_taken),
    .if_pred_pc     (if_pred_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        rrdy;
    logic        ivld;
    logic [31:0] inst;
    logic        ird;
    logic        tk;
    logic [31:0] ppc;
    logic        e_rv;
    logic        e_ir;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_ifpc;
    logic [31:0] e_inst;
    logic        e_pt;
    logic [31:0] e_ppc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rrdy, input logic ivld,
                              input logic [31:0] inst, input logic ird,
                              input logic tk, input logic [31:0] ppc,
                              input logic e_rv, input logic e_ir, input logic e_iv,
                              input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                              input logic [31:0] e_inst, input logic e_pt,
                              input logic [31:0] e_ppc);
    vec_t v;
    v.rst = r; v.rrdy = rrdy; v.ivld = ivld; v.inst = inst; v.ird = ird;
    v.tk = tk; v.ppc = ppc; v.e_rv = e_rv; v.e_ir = e_ir; v.e_iv = e_iv;
    v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_inst = e_inst; v.e_pt = e_pt;
    v.e_ppc = e_ppc;
    return v;
  endfunction

  // Reference behaviour used by the random phase.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic pred_tk(input logic [31:0] a);
    return (a[4:2] == 3'b101);
  endfunction

  function automatic logic [31:0] pred_tg(input logic [31:0] a);
    return a ^ 32'h0000_1240;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Inst_Req_Ready = 1'b0;
    Inst_Valid     = 1'b0;
    Instruction    = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    taken_predict  = 1'b0;
    PC_predict     = 32'h0;
  endtask

  vec_t vecs[9];

  initial begin
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    logic [31:0] exp_pc;
    logic [31:0] exp_npc;
    logic        req_fire, resp_fire, consume, prev_redir;
    int          stall, n_ent;

    // rst rrdy ivld inst ird tk ppc | rv ir iv pc ifpc inst pt ppc
    vecs[0] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,   0, 0, 0, 32'h100, 32'h0,   32'h0,         0, 32'h0);
    vecs[1] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,   0, 0, 0, 32'h100, 32'h0,   32'h0,         0, 32'h0);
    vecs[2] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,   1, 0, 0, 32'h100, 32'h0,   32'h0,         0, 32'h0);
    vecs[3] = mk(1, 1, 0, 32'h0,         0, 0, 32'h0,   0, 1, 0, 32'h100, 32'h0,   32'h0,         0, 32'h0);
    vecs[4] = mk(1, 0, 1, 32'hAAAA_0001, 0, 0, 32'h0,   0, 0, 1, 32'h100, 32'h100, 32'hAAAA_0001, 0, 32'h104);
    vecs[5] = mk(1, 0, 0, 32'h0,         1, 0, 32'h0,   1, 0, 0, 32'h104, 32'h0,   32'h0,         0, 32'h0);
    vecs[6] = mk(1, 1, 0, 32'h0,         0, 1, 32'h200, 0, 1, 0, 32'h104, 32'h0,   32'h0,         0, 32'h0);
    vecs[7] = mk(1, 0, 1, 32'hBBBB_0002, 0, 0, 32'h0,   0, 0, 1, 32'h104, 32'h104, 32'hBBBB_0002, 1, 32'h200);
    vecs[8] = mk(1, 0, 0, 32'h0,         1, 0, 32'h0,   1, 0, 0, 32'h200, 32'h0,   32'h0,         0, 32'h0);

    rst = 1'b0;
    idle_inputs();
    #2;

    // Table-driven reset and basic fetch sequence.
    for (int i = 0; i < 9; i++) begin
      rst            = vecs[i].rst;
      Inst_Req_Ready = vecs[i].rrdy;
      Inst_Valid     = vecs[i].ivld;
      Instruction    = vecs[i].inst;
      if_ready       = vecs[i].ird;
      taken_predict  = vecs[i].tk;
      PC_predict     = vecs[i].ppc;
      tick();
      chk($sformatf("vec%0d_req_valid", i), Inst_Req_Valid, vecs[i].e_rv);
      chk($sformatf("vec%0d_inst_ready", i), Inst_Ready, vecs[i].e_ir);
      chk($sformatf("vec%0d_if_valid", i), if_valid, vecs[i].e_iv);
      chk($sformatf("vec%0d_pc", i), PC, vecs[i].e_pc);
      chk($sformatf("vec%0d_pc_now", i), PC_now, vecs[i].e_pc);
      if (vecs[i].e_iv || !vecs[i].rst)
        chk($sformatf("vec%0d_if_pred_taken", i), if_pred_taken, vecs[i].e_pt);
      if (vecs[i].e_iv) begin
        chk($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].e_ifpc);
        chk($sformatf("vec%0d_if_inst", i), if_inst, vecs[i].e_inst);
        chk($sformatf("vec%0d_if_pred_pc", i), if_pred_pc, vecs[i].e_ppc);
      end
    end
    rst = 1'b1;

    // Redirect in WAIT, stale response three cycles later.
    idle_inputs(); Inst_Req_Ready = 1'b1; tick();
    chk("s1_wait", Inst_Ready, 1);
    idle_inputs(); redirect_valid = 1'b1; redirect_pc = 32'h300; tick();
    chk("s1_redir_pc", PC, 32'h300);
    chk("s1_still_wait", Inst_Ready, 1);
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("s1_no_entry", if_valid, 0);
    end
    Inst_Valid = 1'b1; Instruction = 32'hDEAD_0000; tick();
    chk("s1_discard_no_entry", if_valid, 0);
    chk("s1_back_to_req", Inst_Req_Valid, 1);
    chk("s1_req_pc", PC, 32'h300);

    // Decode stall for five cycles in HOLD.
    idle_inputs(); Inst_Req_Ready = 1'b1; tick();
    idle_inputs(); Inst_Valid = 1'b1; Instruction = 32'hCCCC_0003; tick();
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      chk("s2_hold_valid", if_valid, 1);
      chk("s2_hold_pc", if_pc, 32'h300);
      chk("s2_hold_inst", if_inst, 32'hCCCC_0003);
      chk("s2_no_req", Inst_Req_Valid, 0);
      tick();
    end
    if_ready = 1'b1; tick();
    chk("s2_resume_req", Inst_Req_Valid, 1);
    chk("s2_resume_pc", PC, 32'h304);

    // Redirect and if_ready together in HOLD.
    idle_inputs(); Inst_Req_Ready = 1'b1; tick();
    idle_inputs(); Inst_Valid = 1'b1; Instruction = 32'h1111_0004; tick();
    chk("s3_hold_pc", if_pc, 32'h304);
    idle_inputs(); if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400; tick();
    chk("s3_dropped", if_valid, 0);
    chk("s3_req_pc", PC, 32'h400);

    // Redirect in REQ without handshake, then PC wrap.
    idle_inputs(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick();
    chk("s4_req_pc", PC, 32'hFFFF_FFFC);
    chk("s4_req_valid", Inst_Req_Valid, 1);
    idle_inputs(); Inst_Req_Ready = 1'b1; tick();
    idle_inputs(); Inst_Valid = 1'b1; Instruction = 32'h3333_0005; tick();
    chk("s4_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("s4_wrap_npc", if_pred_pc, 32'h0);
    idle_inputs(); if_ready = 1'b1; tick();
    chk("s4_wrap_pc", PC, 32'h0);

    // Redirect in the same cycle as the request handshake.
    idle_inputs(); Inst_Req_Ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500; tick();
    chk("s5_wait", Inst_Ready, 1);
    chk("s5_pc", PC, 32'h500);
    idle_inputs(); Inst_Valid = 1'b1; Instruction = 32'h2222_0006; tick();
    chk("s5_discard", if_valid, 0);
    chk("s5_req_pc", PC, 32'h500);
    chk("s5_req_valid", Inst_Req_Valid, 1);

    // Response and redirect in the same WAIT cycle.
    idle_inputs(); Inst_Req_Ready = 1'b1; tick();
    idle_inputs(); Inst_Valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h600; tick();
    chk("s6_discard", if_valid, 0);
    chk("s6_req_pc", PC, 32'h600);

    // Reset during WAIT; redirect ignored in IDLE.
    idle_inputs(); Inst_Req_Ready = 1'b1; tick();
    idle_inputs(); rst = 1'b0; tick();
    chk("s7_rst_req_valid", Inst_Req_Valid, 0);
    chk("s7_rst_inst_ready", Inst_Ready, 0);
    chk("s7_rst_if_valid", if_valid, 0);
    chk("s7_rst_pc", PC_now, 32'h100);
    idle_inputs(); rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h700; tick();
    chk("s7_idle_redir_ignored", PC, 32'h100);
    chk("s7_first_req", Inst_Req_Valid, 1);

    // Randomized phase against the stream model.
    mem_busy   = 1'b0;
    mem_addr   = 32'h0;
    mem_cnt    = 0;
    exp_pc     = 32'h100;
    prev_redir = 1'b0;
    stall      = 0;
    n_ent      = 0;
    idle_inputs();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      taken_predict  = pred_tk(PC_now);
      PC_predict     = pred_tg(PC_now);
      Inst_Req_Ready = ($urandom_range(0, 9) < 6);
      if_ready       = ($urandom_range(0, 9) < 7);
      if (mem_busy && mem_cnt == 0) begin
        Inst_Valid  = 1'b1;
        Instruction = memf(mem_addr);
      end else begin
        Inst_Valid  = 1'b0;
        Instruction = $urandom;
        if (mem_busy) mem_cnt--;
      end
      redirect_valid = !prev_redir && ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0)
        redirect_pc = 32'hFFFF_FFF8 | {29'h0, 1'b0, $urandom_range(0, 1) == 1, 2'b00};
      else
        redirect_pc = $urandom & 32'hFFFF_FFFC;
      prev_redir = redirect_valid;

      req_fire  = Inst_Req_Valid && Inst_Req_Ready;
      resp_fire = Inst_Valid && Inst_Ready;
      consume   = if_valid && if_ready && !redirect_valid;

      if (resp_fire) mem_busy = 1'b0;
      if (req_fire) begin
        chk("rnd_one_outstanding", mem_busy, 0);
        chk("rnd_req_addr", PC, exp_pc);
        mem_busy = 1'b1;
        mem_addr = PC;
        mem_cnt  = $urandom_range(0, 3);
      end
      if (consume) begin
        exp_npc = pred_tk(exp_pc) ? pred_tg(exp_pc) : exp_pc + 32'd4;
        chk("rnd_if_pc", if_pc, exp_pc);
        chk("rnd_if_inst", if_inst, memf(exp_pc));
        chk("rnd_if_pred_taken", if_pred_taken, pred_tk(exp_pc));
        chk("rnd_if_pred_pc", if_pred_pc, exp_npc);
        exp_pc = exp_npc;
        n_ent++;
        stall = 0;
      end else begin
        stall++;
      end
      if (redirect_valid) exp_pc = redirect_pc;

      if (stall > 400) begin
        chk("rnd_progress_stall", stall, 0);
        break;
      end
      tick();
    end
    chk("rnd_enough_entries", (n_ent >= 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
